// File: rtl/cam_xclk_sequencer.sv
// Glitch-free camera XCLK generator: divide ratio changes only at period boundaries; 1-cycle registered outputs.
// cfg_ready holds low while a ratio is pending. Optional XCLK_EDGE_STROBE_EN adds xclk_rise/xclk_fall strobes.
module cam_xclk_sequencer #(
  parameter int DIV_WIDTH     = 8,
  parameter int DEFAULT_DIV   = 2,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 cfg_valid,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  output logic                 cfg_ready,
  output logic                 cfg_err,
  output logic                 xclk,
`ifdef XCLK_EDGE_STROBE_EN
  output logic                 xclk_rise,
  output logic                 xclk_fall,
`endif
  output logic                 locked
);

  localparam int PW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [PW-1:0] SETTLE = PW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t               state, state_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n;
  logic [DIV_WIDTH-1:0] active_div, div_n;
  logic [DIV_WIDTH-1:0] pend_div, pend_n;
  logic                 pend_vld, pvld_n;
  logic                 stop, stop_n;
  logic [PW-1:0]        pcnt, pcnt_n;
  logic                 locked_n, err_n, xclk_n;
  logic                 phase_end, apply;

  assign cfg_ready = !pend_vld;
  assign phase_end = (cnt == active_div - 1'b1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      active_div <= DIV_WIDTH'(DEFAULT_DIV);
      pend_div   <= '0;
      pend_vld   <= 1'b0;
      stop       <= 1'b0;
      pcnt       <= '0;
      locked     <= 1'b0;
      cfg_err    <= 1'b0;
      xclk       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      active_div <= div_n;
      pend_div   <= pend_n;
      pend_vld   <= pvld_n;
      stop       <= stop_n;
      pcnt       <= pcnt_n;
      locked     <= locked_n;
      cfg_err    <= err_n;
      xclk       <= xclk_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    div_n    = active_div;
    pend_n   = pend_div;
    pvld_n   = pend_vld;
    stop_n   = stop;
    pcnt_n   = pcnt;
    locked_n = locked;
    err_n    = 1'b0;
    apply    = 1'b0;

    // A zero divide is acknowledged but dropped, flagged by cfg_err.
    if (cfg_valid && !pend_vld) begin
      if (cfg_div == '0) begin
        err_n = 1'b1;
      end else begin
        pvld_n = 1'b1;
        pend_n = cfg_div;
      end
    end

    case (state)
      IDLE: begin
        apply = pend_vld;
        cnt_n = '0;
        if (enable) state_n = HIGH;
      end
      HIGH: begin
        if (!enable) begin
          stop_n   = 1'b1;
          locked_n = 1'b0;
        end
        if (phase_end) begin
          state_n = LOW;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      LOW: begin
        if (!enable) begin
          stop_n   = 1'b1;
          locked_n = 1'b0;
        end
        if (phase_end) begin
          // Period boundary: the only point where a running clock may stop or change ratio.
          cnt_n = '0;
          apply = pend_vld;
          if (stop || !enable) begin
            state_n  = IDLE;
            stop_n   = 1'b0;
            pcnt_n   = '0;
            locked_n = 1'b0;
          end else begin
            state_n = HIGH;
            if (pcnt != SETTLE) pcnt_n = pcnt + 1'b1;
            locked_n = (pcnt_n == SETTLE);
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    if (apply) begin
      div_n    = pend_div;
      pvld_n   = 1'b0;
      pcnt_n   = '0;
      locked_n = 1'b0;
    end

    xclk_n = (state_n == HIGH);
  end

`ifdef XCLK_EDGE_STROBE_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      xclk_rise <= 1'b0;
      xclk_fall <= 1'b0;
    end else begin
      xclk_rise <= xclk_n & ~xclk;
      xclk_fall <= ~xclk_n & xclk;
    end
  end
`endif

endmodule

// File: tb/tb_cam_xclk_sequencer.sv
// Directed bench for cam_xclk_sequencer (DEFAULT_DIV=2, SETTLE_CYCLES=4): vector table plus hand sequences.
module tb_cam_xclk_sequencer;

  logic       clock = 1'b0;
  logic       reset, enable, cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready, cfg_err, xclk, locked;
`ifdef XCLK_EDGE_STROBE_EN
  logic       xclk_rise, xclk_fall;
`endif

  cam_xclk_sequencer #(
    .DIV_WIDTH(8), .DEFAULT_DIV(2), .SETTLE_CYCLES(4)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .xclk(xclk),
`ifdef XCLK_EDGE_STROBE_EN
    .xclk_rise(xclk_rise), .xclk_fall(xclk_fall),
`endif
    .locked(locked)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst, en, vld;
    logic [7:0] div;
    logic       x, l, r, e;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic rst, input logic en, input logic vld, input logic [7:0] div,
                              input logic x, input logic l, input logic r, input logic e);
    vec_t v;
    v.rst = rst; v.en = en; v.vld = vld; v.div = div;
    v.x = x; v.l = l; v.r = r; v.e = e;
    vecs.push_back(v);
  endfunction

  // Free run from IDLE at div 2: 1,1,0,0 pattern, locked from the 17th edge on.
  function automatic void add_run(input int n);
    for (int k = 0; k < n; k++)
      add(1, 1, 0, 0, (k % 4) < 2, k >= 16, 1, 0);
  endfunction

  initial begin
    int n, hi;
    bit found;

    // reset state
    add(0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 8'd7, 0, 0, 1, 0);
    // lock at default ratio
    add_run(20);
    // stop requested in first HIGH cycle, enable re-raised during drain
    add(1, 1, 0, 0, 1, 1, 1, 0);
    add(1, 0, 0, 0, 1, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0);
    // relock, then zero divide rejected
    add_run(20);
    add(1, 1, 1, 8'd0, 1, 1, 1, 1);
    add(1, 1, 0, 0, 1, 1, 1, 0);
    add(1, 1, 0, 0, 0, 1, 1, 0);
    add(1, 1, 0, 0, 0, 1, 1, 0);
    add(1, 1, 0, 0, 1, 1, 1, 0);
    // div 3 accepted mid-HIGH, applied at next boundary
    add(1, 1, 1, 8'd3, 1, 1, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 1, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0, 1, 0);
    // pending div 5 then reset mid-LOW
    add(1, 1, 1, 8'd5, 1, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0);
    add_run(5);
    // reset mid-HIGH drops the pulse at once
    add(0, 1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; enable = vecs[i].en;
      cfg_valid = vecs[i].vld; cfg_div = vecs[i].div;
      @(posedge clock); #1;
      check($sformatf("v%0d xclk", i), 32'(xclk), 32'(vecs[i].x));
      check($sformatf("v%0d locked", i), 32'(locked), 32'(vecs[i].l));
      check($sformatf("v%0d cfg_ready", i), 32'(cfg_ready), 32'(vecs[i].r));
      check($sformatf("v%0d cfg_err", i), 32'(cfg_err), 32'(vecs[i].e));
    end

    // lock latency with a bounded wait
    reset = 0; enable = 0; cfg_valid = 0; cfg_div = 0;
    @(posedge clock); #1;
    reset = 1; enable = 1;
    found = 0; n = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge clock); #1;
      if (locked) begin found = 1; n = c; end
    end
    check("lock_edge", found ? n : 999, 16);

    // stop and ratio apply land on the same boundary
    cfg_valid = 1; cfg_div = 8'd4; enable = 0;
    @(posedge clock); #1;
    check("both_ready_low", 32'(cfg_ready), 0);
    check("both_locked_clr", 32'(locked), 0);
    cfg_valid = 0;
    repeat (3) @(posedge clock);
    #1;
    check("both_idle_xclk", 32'(xclk), 0);
    check("both_ready_back", 32'(cfg_ready), 1);
    @(posedge clock); #1;
    check("both_still_idle", 32'(xclk), 0);
    enable = 1;
    hi = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clock); #1;
      if (xclk) hi++;
      else if (hi > 0) break;
    end
    check("both_new_high_len", hi, 4);

`ifdef XCLK_EDGE_STROBE_EN
    reset = 0; enable = 0;
    @(posedge clock); #1;
    check("strobe_rst_rise", 32'(xclk_rise), 0);
    check("strobe_rst_fall", 32'(xclk_fall), 0);
    reset = 1; enable = 1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock); #1;
      check($sformatf("rise_c%0d", k), 32'(xclk_rise), 32'((k % 4) == 0));
      check($sformatf("fall_c%0d", k), 32'(xclk_fall), 32'((k % 4) == 2));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
